// File: rtl/chip8_ps2_pkg.sv
// Shared constants, frame-state encoding and scan-code lookup for the PS/2 keypad front end.
package chip8_ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    // Returns {hit, key}; hit = 0 for codes outside the hex keypad layout.
    function automatic logic [4:0] scan_to_key(input logic [7:0] code);
        logic [4:0] res;
        res = 5'h00;
        case (code)
            8'h16: res = {1'b1, 4'h1};
            8'h1E: res = {1'b1, 4'h2};
            8'h26: res = {1'b1, 4'h3};
            8'h25: res = {1'b1, 4'hC};
            8'h15: res = {1'b1, 4'h4};
            8'h1D: res = {1'b1, 4'h5};
            8'h24: res = {1'b1, 4'h6};
            8'h2D: res = {1'b1, 4'hD};
            8'h1C: res = {1'b1, 4'h7};
            8'h1B: res = {1'b1, 4'h8};
            8'h23: res = {1'b1, 4'h9};
            8'h2B: res = {1'b1, 4'hE};
            8'h1A: res = {1'b1, 4'hA};
            8'h22: res = {1'b1, 4'h0};
            8'h21: res = {1'b1, 4'hB};
            8'h2A: res = {1'b1, 4'hF};
            default: res = 5'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line synchronisers, clock glitch filter,
// 11-bit frame deframer with odd-parity/stop checking and mid-frame timeout.
module ps2_rx
    import chip8_ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_s;
    logic                   data_s;

    logic          filt_reg, filt_next;
    logic [FW-1:0] filt_cnt_reg, filt_cnt_next;
    logic          fall_reg;

    frame_state_t  state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          rx_valid_reg, rx_valid_next;
    logic [7:0]    rx_byte_reg;
    logic          frame_error_reg, frame_error_next;

    assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];

    // Filtered level flips only once FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_next     = filt_reg;
        filt_cnt_next = '0;
        if (clk_s != filt_reg) begin
            if (filt_cnt_reg == FW'(FILTER_LEN - 1))
                filt_next = clk_s;
            else
                filt_cnt_next = filt_cnt_reg + FW'(1);
        end
    end

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        to_cnt_next      = '0;
        rx_valid_next    = 1'b0;
        frame_error_next = 1'b0;

        // A fall in the same cycle as the timeout takes priority.
        if (state_reg != IDLE && !fall_reg) begin
            if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next       = IDLE;
                frame_error_next = 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg + TW'(1);
            end
        end

        if (fall_reg) begin
            case (state_reg)
                IDLE: begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
                DATA: begin
                    shift_next   = {data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = PARITY;
                end
                PARITY: begin
                    parity_next = data_s;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if ((^{shift_reg, parity_reg}) && data_s)
                        rx_valid_next = 1'b1;
                    else
                        frame_error_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg    <= '1;
            data_sync_reg   <= '1;
            filt_reg        <= 1'b1;
            filt_cnt_reg    <= '0;
            fall_reg        <= 1'b0;
            state_reg       <= IDLE;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 8'h00;
            parity_reg      <= 1'b0;
            to_cnt_reg      <= '0;
            rx_valid_reg    <= 1'b0;
            rx_byte_reg     <= 8'h00;
            frame_error_reg <= 1'b0;
        end else begin
            clk_sync_reg    <= SYNC_STAGES'({clk_sync_reg, ps2_clk});
            data_sync_reg   <= SYNC_STAGES'({data_sync_reg, ps2_data});
            filt_reg        <= filt_next;
            filt_cnt_reg    <= filt_cnt_next;
            fall_reg        <= filt_reg & ~filt_next;
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            to_cnt_reg      <= to_cnt_next;
            rx_valid_reg    <= rx_valid_next;
            frame_error_reg <= frame_error_next;
            if (rx_valid_next)
                rx_byte_reg <= shift_reg;
        end
    end

    assign rx_valid    = rx_valid_reg;
    assign rx_byte     = rx_byte_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard to Chip-8 hex keypad matrix: make/break/extended prefix decode
// on top of the synchronous frame receiver.
module ps2_key_matrix
    import chip8_ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_matrix,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        any_key,
    output logic        frame_error
);
    logic       rx_valid;
    logic [7:0] rx_byte;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .frame_error(frame_error)
    );

    logic        break_reg, break_next;
    logic        ext_reg, ext_next;
    logic [15:0] matrix_reg, matrix_next;
    logic        key_event_reg;
    logic [3:0]  key_code_reg;
    logic        key_down_reg;
    logic        any_key_reg;

    logic [4:0]  hit_key;
    logic        is_prefix;
    logic        new_level;
    logic        write_en;

    assign hit_key   = scan_to_key(rx_byte);
    assign is_prefix = (rx_byte == SC_BREAK) || (rx_byte == SC_EXT);
    assign new_level = ~break_reg;
    // Only a real level change writes, so typematic repeats stay silent.
    assign write_en  = rx_valid && !is_prefix && !ext_reg && hit_key[4] &&
                       (matrix_reg[hit_key[3:0]] != new_level);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_key
            assign matrix_next[gi] = (write_en && hit_key[3:0] == 4'(gi)) ? new_level
                                                                          : matrix_reg[gi];
        end
    endgenerate

    always_comb begin
        break_next = break_reg;
        ext_next   = ext_reg;
        if (rx_valid) begin
            if (rx_byte == SC_BREAK) begin
                break_next = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_next = 1'b1;
            end else begin
                break_next = 1'b0;
                ext_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_reg     <= 1'b0;
            ext_reg       <= 1'b0;
            matrix_reg    <= 16'h0000;
            key_event_reg <= 1'b0;
            key_code_reg  <= 4'h0;
            key_down_reg  <= 1'b0;
            any_key_reg   <= 1'b0;
        end else begin
            break_reg     <= break_next;
            ext_reg       <= ext_next;
            matrix_reg    <= matrix_next;
            key_event_reg <= write_en;
            any_key_reg   <= |matrix_next;
            if (write_en) begin
                key_code_reg <= hit_key[3:0];
                key_down_reg <= new_level;
            end
        end
    end

    assign key_matrix = matrix_reg;
    assign key_event  = key_event_reg;
    assign key_code   = key_code_reg;
    assign key_down   = key_down_reg;
    assign any_key    = any_key_reg;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: drives PS/2 frames and checks keypad matrix,
// events, error pulses, timeout, glitch rejection and asynchronous reset.
module tb_ps2_key_matrix;

    localparam int HALF     = 40;
    localparam int SYNC_N   = 2;
    localparam int FILT_N   = 8;
    localparam int TIMEOUT  = 20000;
    localparam int LAT_EXP  = SYNC_N + FILT_N + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_matrix;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_down;
    logic        any_key;
    logic        frame_error;

    ps2_key_matrix #(
        .SYNC_STAGES   (SYNC_N),
        .FILTER_LEN    (FILT_N),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_matrix (key_matrix),
        .key_event  (key_event),
        .key_code   (key_code),
        .key_down   (key_down),
        .any_key    (any_key),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         ev_cnt;
    int         err_cnt;
    int         ev_lat;
    logic [3:0] ev_code;
    logic       ev_down;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then clock low with outputs watched.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            cyc(10);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(HALF - 13);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            cyc(1);
            if (key_event) begin
                ev_cnt++;
                ev_code = key_code;
                ev_down = key_down;
                if (ev_lat == 0) ev_lat = i;
            end
            if (frame_error) err_cnt++;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic clear_obs();
        ev_cnt  = 0;
        err_cnt = 0;
        ev_lat  = 0;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit glitch);
        logic par;
        clear_obs();
        par = ~(^code) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], glitch);
        ps2_bit(par, glitch);
        ps2_bit(1'b1, glitch);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic send_partial(input logic [7:0] code, input int nbits);
        clear_obs();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(code[i], 1'b0);
    endtask

    initial begin
        int tot;
        int t;

        // Reset state
        cyc(3);
        check("rst_key_matrix", key_matrix, 16'h0000);
        check("rst_key_event", key_event, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_down", key_down, 1'b0);
        check("rst_any_key", any_key, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        rst_n = 1'b1;
        cyc(5);

        // Make 1E -> key 2
        send_frame(8'h1E, 1'b0, 1'b0);
        check("make2_latency", ev_lat, LAT_EXP);
        check("make2_events", ev_cnt, 1);
        check("make2_code", ev_code, 4'h2);
        check("make2_down", ev_down, 1'b1);
        check("make2_matrix", key_matrix, 16'h0004);
        check("make2_any", any_key, 1'b1);

        // Break F0,1E
        send_frame(8'hF0, 1'b0, 1'b0);
        check("brk_prefix_events", ev_cnt, 0);
        send_frame(8'h1E, 1'b0, 1'b0);
        check("brk2_events", ev_cnt, 1);
        check("brk2_code", ev_code, 4'h2);
        check("brk2_down", ev_down, 1'b0);
        check("brk2_matrix", key_matrix, 16'h0000);
        check("brk2_any", any_key, 1'b0);

        // Typematic: three makes, one event
        tot = 0;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h1E, 1'b0, 1'b0);
            tot += ev_cnt;
        end
        check("typematic_events", tot, 1);
        check("typematic_matrix", key_matrix, 16'h0004);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1E, 1'b0, 1'b0);
        check("release2_matrix", key_matrix, 16'h0000);

        // Extended codes ignored, then 22 -> key 0
        tot = 0;
        send_frame(8'hE0, 1'b0, 1'b0); tot += ev_cnt;
        send_frame(8'h75, 1'b0, 1'b0); tot += ev_cnt;
        send_frame(8'hE0, 1'b0, 1'b0); tot += ev_cnt;
        send_frame(8'h1C, 1'b0, 1'b0); tot += ev_cnt;
        check("ext_events", tot, 0);
        check("ext_matrix", key_matrix, 16'h0000);
        send_frame(8'h22, 1'b0, 1'b0);
        check("key0_events", ev_cnt, 1);
        check("key0_code", ev_code, 4'h0);
        check("key0_matrix", key_matrix, 16'h0001);

        // Parity error, then good 16 -> key 1
        send_frame(8'h16, 1'b1, 1'b0);
        check("parity_err_pulses", err_cnt, 1);
        check("parity_err_events", ev_cnt, 0);
        check("parity_err_matrix", key_matrix, 16'h0001);
        send_frame(8'h16, 1'b0, 1'b0);
        check("key1_err", err_cnt, 0);
        check("key1_matrix", key_matrix, 16'h0003);

        // Timeout after 4 data bits
        send_partial(8'h2A, 4);
        check("timeout_no_early_err", err_cnt, 0);
        t = 0;
        while (!frame_error && t < 25000) begin
            cyc(1);
            t++;
        end
        tot = HALF + t;
        check("timeout_seen", frame_error, 1'b1);
        check("timeout_window", (tot >= TIMEOUT && tot <= TIMEOUT + 20), 1'b1);
        cyc(HALF);
        send_frame(8'h2A, 1'b0, 1'b0);
        check("keyF_err", err_cnt, 0);
        check("keyF_matrix", key_matrix, 16'h8003);

        // Unmapped bytes
        tot = 0;
        send_frame(8'hAA, 1'b0, 1'b0); tot += ev_cnt;
        send_frame(8'hFA, 1'b0, 1'b0); tot += ev_cnt;
        check("unmapped_events", tot, 0);
        check("unmapped_matrix", key_matrix, 16'h8003);

        // Glitches on every high phase must not shift bits
        send_frame(8'h1D, 1'b0, 1'b1);
        check("glitch_err", err_cnt, 0);
        check("glitch_code", ev_code, 4'h5);
        check("glitch_matrix", key_matrix, 16'h8023);

        // Asynchronous reset mid-frame
        send_partial(8'h1E, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_matrix", key_matrix, 16'h0000);
        check("async_rst_any", any_key, 1'b0);
        ps2_data = 1'b1;
        cyc(4);
        rst_n = 1'b1;
        cyc(HALF);
        send_frame(8'h1E, 1'b0, 1'b0);
        check("post_rst_err", err_cnt, 0);
        check("post_rst_matrix", key_matrix, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
